// File: rtl/mat_mem_streamer.sv
// mat_mem_streamer: writes one m x n matrix into a block-RAM store and streams it back, row- or column-major.
// A 2-entry buffer and a read credit check absorb the store's 1-cycle registered read latency.
module mat_mem_streamer #(
    parameter int DW = 8,
    parameter int m  = 8,
    parameter int n  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_wr,
    input  logic              start_rd,
    input  logic              transpose,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*DW-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-1:0]   out_data,
    output logic              busy,
    output logic              done,
    output logic              mem_ramEN,
    output logic              mem_writeEN,
    output logic              mem_readEN,
    output logic [m+n-1:0]    mem_addr,
    output logic [m+n-1:0]    mem_wdata,
    input  logic [2*DW-1:0]   mem_rdata
);
    localparam int N   = m * n;
    localparam int AW  = m + n;
    localparam int RW  = m > 1 ? $clog2(m) : 1;
    localparam int CLW = n > 1 ? $clog2(n) : 1;
    localparam int CW  = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t          state, state_nx;
    logic [RW-1:0]   row;
    logic [CLW-1:0]  col;
    logic [CW-1:0]   issued, popped;
    logic            tr, inflight, done_q;
    logic [1:0]      cnt;
    logic [2*DW-1:0] b0, b1;
    logic            wr_hs, pop, issue, adv, last_row, last_col;
    logic [AW-1:0]   idx;

    assign wr_hs    = state == WRITE && in_valid;
    assign pop      = out_valid && out_ready;
    // buffer occupancy after this cycle's pop, counting the read already in flight
    assign issue    = state == READ && issued < CW'(N) &&
                      ({1'b0, cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
    assign adv      = wr_hs || issue;
    assign last_row = row == RW'(m - 1);
    assign last_col = col == CLW'(n - 1);
    assign idx      = AW'(row) * AW'(n) + AW'(col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = start_wr ? WRITE : start_rd ? READ : IDLE;
        else if (state == WRITE)
            state_nx = (wr_hs && issued == CW'(N - 1)) ? IDLE : WRITE;
        else
            state_nx = (pop && popped == CW'(N - 1)) ? IDLE : READ;
    end

    always_comb begin
        in_ready    = state == WRITE;
        busy        = state != IDLE;
        done        = done_q;
        out_valid   = cnt != 2'd0;
        out_data    = b0;
        mem_ramEN   = adv;
        mem_writeEN = wr_hs;
        mem_readEN  = issue;
        mem_addr    = adv ? idx : '0;
        mem_wdata   = wr_hs ? AW'(in_data) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row      <= '0;
            col      <= '0;
            issued   <= '0;
            popped   <= '0;
            tr       <= 1'b0;
            inflight <= 1'b0;
            done_q   <= 1'b0;
            cnt      <= 2'd0;
            b0       <= '0;
            b1       <= '0;
        end else begin
            done_q   <= state != IDLE && state_nx == IDLE;
            inflight <= issue;
            if (state == IDLE) begin
                row    <= '0;
                col    <= '0;
                issued <= '0;
                popped <= '0;
                tr     <= start_rd && !start_wr && transpose;
            end else begin
                if (adv) begin
                    issued <= issued + 1'b1;
                    if (tr && state == READ) begin
                        row <= last_row ? '0 : row + 1'b1;
                        if (last_row)
                            col <= last_col ? '0 : col + 1'b1;
                    end else begin
                        col <= last_col ? '0 : col + 1'b1;
                        if (last_col)
                            row <= last_row ? '0 : row + 1'b1;
                    end
                end
                if (pop)
                    popped <= popped + 1'b1;
            end
            case ({inflight, pop})
                2'b10: begin
                    if (cnt == 2'd0)
                        b0 <= mem_rdata;
                    else
                        b1 <= mem_rdata;
                    cnt <= cnt + 1'b1;
                end
                2'b01: begin
                    b0  <= b1;
                    cnt <= cnt - 1'b1;
                end
                2'b11: begin
                    b0 <= cnt == 2'd1 ? mem_rdata : b1;
                    b1 <= mem_rdata;
                end
                default: ;
            endcase
        end
    end
endmodule
